// File: rtl/fir_pkg.sv
// Shared types, default widths and arithmetic helpers for the FIR MAC sequencer.
package fir_pkg;

    localparam int unsigned DEF_NTAPS = 4;
    localparam int unsigned DEF_DW    = 8;
    localparam int unsigned DEF_CW    = 8;
    localparam int unsigned DEF_OW    = 16;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } fir_state_e;

    // Power-on coefficient for tap k is k+1, giving a ramp 1,2,3,...
    function automatic logic [31:0] defaultCoef(input int unsigned k);
        return 32'(k + 1);
    endfunction

    // Clamp an unsigned value to the largest value representable in ow bits.
    function automatic logic [63:0] satValue(input logic [63:0] v, input int unsigned ow);
        logic [63:0] maxVal;
        maxVal = (64'd1 << ow) - 64'd1;
        return (v > maxVal) ? maxVal : v;
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Coefficient register file: reset to the default ramp, one write port,
// combinational read of the tap currently being accumulated.
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int NTAPS = DEF_NTAPS,
    parameter int CW    = DEF_CW,
    parameter int KW    = $clog2(NTAPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [KW-1:0] waddr_i,
    input  logic [CW-1:0] wdata_i,
    input  logic [KW-1:0] raddr_i,
    output logic [CW-1:0] rdata_o
);

    logic [CW-1:0] coefMem_q [NTAPS];

    // Coefficient storage; writes to an index beyond the last tap are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                coefMem_q[i] <= CW'(defaultCoef(i));
            end
        end else if (we_i && ({1'b0, waddr_i} < (KW+1)'(NTAPS))) begin
            coefMem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = coefMem_q[raddr_i];

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one multiplier and one accumulator walk the taps
// over NTAPS cycles per sample, with valid/ready on both sides and a
// runtime-writable coefficient bank.
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int NTAPS = DEF_NTAPS,
    parameter int DW    = DEF_DW,
    parameter int CW    = DEF_CW,
    parameter int OW    = DEF_OW,
    parameter int AW    = DW + CW + $clog2(NTAPS),
    parameter int KW    = $clog2(NTAPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [OW-1:0] out_data,
    input  logic          out_ready,
    input  logic          coef_we,
    input  logic [KW-1:0] coef_addr,
    input  logic [CW-1:0] coef_wdata,
    output logic          coef_ready,
    input  logic          flush,
    output logic          busy
);

    fir_state_e    state_q, state_d;
    logic [DW-1:0] hist_q [NTAPS];
    logic [AW-1:0] acc_q;
    logic [KW-1:0] tapIdx_q;
    logic [OW-1:0] outData_q;
    logic          outValid_q;

    logic [CW-1:0]    coefRd;
    logic [DW-1:0]    histSel;
    logic [CW+DW-1:0] product;
    logic [AW-1:0]    accSum;
    logic [OW-1:0]    satSum;
    logic             isIdle;
    logic             lastTap;
    logic             coefWrite;
    logic             acceptSample;

    assign isIdle       = (state_q == IDLE);
    assign lastTap      = (tapIdx_q == KW'(NTAPS - 1));
    assign coefWrite    = isIdle && coef_we;
    assign acceptSample = isIdle && !flush && in_valid;

    assign histSel = hist_q[tapIdx_q];
    assign product = {{DW{1'b0}}, coefRd} * {{CW{1'b0}}, histSel};
    assign accSum  = acc_q + AW'(product);
    assign satSum  = OW'(satValue(64'(accSum), OW));

    fir_coef_bank #(
        .NTAPS (NTAPS),
        .CW    (CW),
        .KW    (KW)
    ) uCoefBank (
        .clk     (clk),
        .rst     (rst),
        .we_i    (coefWrite),
        .waddr_i (coef_addr),
        .wdata_i (coef_wdata),
        .raddr_i (tapIdx_q),
        .rdata_o (coefRd)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: accept -> walk taps -> hold result until consumed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (acceptSample)        state_d = MAC;
            MAC:     if (lastTap)             state_d = OUT;
            OUT:     if (out_ready)           state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    // Handshake outputs depend only on the current state.
    always_comb begin
        in_ready   = isIdle;
        coef_ready = isIdle;
        busy       = !isIdle;
    end

    // Sample history, accumulator, tap counter and the registered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                hist_q[i] <= '0;
            end
            acc_q      <= '0;
            tapIdx_q   <= '0;
            outData_q  <= '0;
            outValid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (flush) begin
                        for (int i = 0; i < NTAPS; i++) begin
                            hist_q[i] <= '0;
                        end
                    end else if (in_valid) begin
                        for (int i = NTAPS - 1; i > 0; i--) begin
                            hist_q[i] <= hist_q[i-1];
                        end
                        hist_q[0] <= in_data;
                        acc_q     <= '0;
                        tapIdx_q  <= '0;
                    end
                end
                MAC: begin
                    acc_q    <= accSum;
                    tapIdx_q <= tapIdx_q + KW'(1);
                    if (lastTap) begin
                        outData_q  <= satSum;
                        outValid_q <= 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                    end
                end
                default: begin
                    outValid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_data  = outData_q;
    assign out_valid = outValid_q;

endmodule
